sync_tff_downcounter: RTL

Parameterized synchronous down counter built from T flip-flops, with parallel load, enable, one-shot/periodic mode and a registered terminal-count pulse. It counts from a loaded value to zero and either stops or auto-reloads. It is the count-down companion to the team's T-FF up counter and serves as the timer/divider primitive for sequential-logic blocks.

---
 rtl/sync_tff_downcounter_pkg.sv | 17 +
 rtl/sync_tff_downcounter_tff_cell.sv | 17 +
 rtl/sync_tff_downcounter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sync_tff_downcounter_pkg.sv
// Shared definitions for the T-flip-flop down counter: state encoding and width bounds.
package sync_tff_downcounter_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/sync_tff_downcounter_tff_cell.sv
// Single T flip-flop with asynchronous active-low reset to 0.
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/sync_tff_downcounter.sv
// Down counter built from T flip-flops, with parallel load, one-shot/periodic
// auto-reload and a registered terminal-count pulse.
module sync_tff_downcounter
  import sync_tff_downcounter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  logic             r_mode;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_dec_t;
  logic [WIDTH-1:0] w_t;
  logic             w_q_zero;
  logic             w_q_one;

  assign w_q_zero = (w_q == '0);
  assign w_q_one  = (w_q == WIDTH'(1));

  // Decrement toggle chain: bit i toggles when all lower bits are 0.
  assign w_dec_t[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign w_dec_t[i] = w_dec_t[i-1] & ~w_q[i-1];
  end

  // Loads drive t as q ^ target so the cells land on the target value.
  always_comb begin
    w_t = '0;
    if (load) begin
      w_t = w_q ^ load_val;
    end else begin
      unique case (r_state)
        StRun: begin
          if (en) begin
            if (w_q_zero) w_t = w_q ^ r_reload;
            else          w_t = w_dec_t;
          end
        end
        StDone: begin
          if (start) w_t = w_q ^ r_reload;
        end
        default: w_t = '0;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (w_t[i]),
      .q     (w_q[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_mode   <= 1'b0;
      r_reload <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (load) begin
        r_reload <= load_val;
        r_state  <= StIdle;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (start) begin
              r_mode <= mode;
              if (w_q_zero) begin
                r_state <= StDone;
                r_tc    <= 1'b1;
              end else begin
                r_state <= StRun;
              end
            end
          end
          StRun: begin
            if (en) begin
              if (w_q_one) begin
                r_tc <= 1'b1;
                if (!r_mode) r_state <= StDone;
              end else if (w_q_zero) begin
                r_tc <= (r_reload == '0);
              end
            end
          end
          StDone: begin
            if (start) begin
              r_mode <= mode;
              if (r_reload != '0) r_state <= StRun;
              else                r_tc    <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign q    = w_q;
  assign tc   = r_tc;
  assign busy = (r_state == StRun);
  assign done = (r_state == StDone);

endmodule
